// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD,
        CLS_ST,
        CLS_LDI,
        CLS_MOV,
        CLS_ALU,
        CLS_ADDI,
        CLS_JZ,
        CLS_JC,
        CLS_HLT
    } iclass_t;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_MOV  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_IMM  = 2'b10;
    localparam logic [1:0] WB_REG  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: splits the IR into class, ALU function,
// write-back source, register fields, immediate and branch offset.
module cu_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RF_AW  = 2
)
(
    input  logic [DATA_W-1:0] ir,
    output iclass_t           iclass,
    output logic [2:0]        alu_op,
    output logic [1:0]        wb_sel,
    output logic              writes_rf,
    output logic              writes_flags,
    output logic [DATA_W-1:0] imm_ext,
    output logic [RF_AW-1:0]  rd,
    output logic [RF_AW-1:0]  rs,
    output logic [3:0]        br_off
);

    logic [3:0] opcode;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign rd      = ir[2*RF_AW-1 -: RF_AW];
    assign rs      = ir[RF_AW-1:0];
    assign br_off  = ir[3:0];
    assign imm_ext = {{(DATA_W-2){ir[1]}}, ir[1:0]};

    // Opcodes 4..B fall through to the ALU class; their function is opcode-4 mod 8.
    always_comb begin
        iclass       = CLS_ALU;
        alu_op       = opcode[2:0] - 3'd4;
        wb_sel       = WB_ALU;
        writes_rf    = 1'b1;
        writes_flags = 1'b1;
        case (opcode)
            OP_LD: begin
                iclass       = CLS_LD;
                wb_sel       = WB_DMEM;
                writes_flags = 1'b0;
            end
            OP_ST: begin
                iclass       = CLS_ST;
                writes_rf    = 1'b0;
                writes_flags = 1'b0;
            end
            OP_LDI: begin
                iclass       = CLS_LDI;
                wb_sel       = WB_IMM;
                writes_flags = 1'b0;
            end
            OP_MOV: begin
                iclass       = CLS_MOV;
                wb_sel       = WB_REG;
                writes_flags = 1'b0;
            end
            OP_ADDI: begin
                iclass = CLS_ADDI;
                alu_op = ALU_ADD;
            end
            OP_JZ: begin
                iclass       = CLS_JZ;
                writes_rf    = 1'b0;
                writes_flags = 1'b0;
            end
            OP_JC: begin
                iclass       = CLS_JC;
                writes_rf    = 1'b0;
                writes_flags = 1'b0;
            end
            OP_HLT: begin
                iclass       = CLS_HLT;
                writes_rf    = 1'b0;
                writes_flags = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with IR and Z/C/S flags.
// Define CU_WAIT_EN to hold MEM strobes until dmem_rdy; otherwise MEM is one cycle.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RF_AW  = 2,
    parameter int PC_W   = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] imem_data,
    input  logic [PC_W-1:0]   pc,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_s,
    input  logic              dmem_rdy,
    output logic              imem_re,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_target,
    output logic [RF_AW-1:0]  rf_ra,
    output logic [RF_AW-1:0]  rf_rb,
    output logic [RF_AW-1:0]  rf_wa,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic [2:0]        alu_op,
    output logic              alu_b_imm,
    output logic [DATA_W-1:0] imm_ext,
    output logic              dm_re,
    output logic              dm_we,
    output logic [2:0]        flags,
    output logic              halted
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;
    logic [2:0]        flags_q;

    iclass_t           iclass;
    logic [2:0]        dec_alu_op;
    logic [1:0]        dec_wb_sel;
    logic              writes_rf;
    logic              writes_flags;
    logic [RF_AW-1:0]  rd;
    logic [RF_AW-1:0]  rs;
    logic [3:0]        br_off;

    logic              is_alu_cls;
    logic              branch_taken;
    logic              fetch_re;
    logic [PC_W-1:0]   br_target;

    cu_decode #(
        .DATA_W (DATA_W),
        .RF_AW  (RF_AW)
    ) u_decode (
        .ir           (ir),
        .iclass       (iclass),
        .alu_op       (dec_alu_op),
        .wb_sel       (dec_wb_sel),
        .writes_rf    (writes_rf),
        .writes_flags (writes_flags),
        .imm_ext      (imm_ext),
        .rd           (rd),
        .rs           (rs),
        .br_off       (br_off)
    );

    assign is_alu_cls   = (iclass == CLS_ALU) || (iclass == CLS_ADDI);
    assign branch_taken = ((iclass == CLS_JZ) && flags_q[2]) ||
                          ((iclass == CLS_JC) && flags_q[1]);
    assign br_target    = pc + {{(PC_W-4){br_off[3]}}, br_off};

    assign rf_ra = rd;
    assign rf_rb = rs;
    assign rf_wa = rd;
    assign flags = flags_q;

    // FETCH is the reset state, so the fetch strobe is masked while reset is held.
    assign imem_re = fetch_re & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            flags_q <= '0;
        end else begin
            if (state == DECODE) begin
                ir <= imem_data;
            end
            if ((state == EXEC) && writes_flags) begin
                flags_q <= {alu_z, alu_c, alu_s};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fetch_re  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        alu_op    = ALU_ADD;
        alu_b_imm = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                fetch_re  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                if (is_alu_cls) begin
                    alu_op    = dec_alu_op;
                    alu_b_imm = (iclass == CLS_ADDI);
                end
                case (iclass)
                    CLS_LD, CLS_ST: state_nxt = MEM;
                    CLS_JZ, CLS_JC: begin
                        if (branch_taken) begin
                            pc_load   = 1'b1;
                            pc_target = br_target;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_nxt = FETCH;
                    end
                    CLS_HLT: state_nxt = HALT;
                    default: state_nxt = WB;
                endcase
            end
            MEM: begin
                dm_re = (iclass == CLS_LD);
                dm_we = (iclass == CLS_ST);
`ifdef CU_WAIT_EN
                if (dmem_rdy) begin
                    state_nxt = WB;
                end
`else
                state_nxt = WB;
`endif
            end
            WB: begin
                // ALU controls stay valid so the datapath result is stable at write-back.
                if (is_alu_cls) begin
                    alu_op    = dec_alu_op;
                    alu_b_imm = (iclass == CLS_ADDI);
                end
                rf_we     = writes_rf;
                wb_sel    = dec_wb_sel;
                pc_inc    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

`ifndef CU_WAIT_EN
    logic unused_dmem_rdy;
    assign unused_dmem_rdy = dmem_rdy;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a spec-level model queues per-cycle expected
// outputs (with care masks) and each test task pops and compares them cycle by cycle.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [7:0] imem_data;
    logic [7:0] pc;
    logic       alu_z;
    logic       alu_c;
    logic       alu_s;
    logic       dmem_rdy;
    logic       imem_re;
    logic       pc_inc;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic [1:0] rf_wa;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       alu_b_imm;
    logic [7:0] imm_ext;
    logic       dm_re;
    logic       dm_we;
    logic [2:0] flags;
    logic       halted;

    typedef struct packed {
        logic       imem_re;
        logic       pc_inc;
        logic       pc_load;
        logic [7:0] pc_target;
        logic [1:0] rf_ra;
        logic [1:0] rf_rb;
        logic [1:0] rf_wa;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [2:0] alu_op;
        logic       alu_b_imm;
        logic [7:0] imm_ext;
        logic       dm_re;
        logic       dm_we;
        logic [2:0] flags;
        logic       halted;
    } obs_t;

    typedef struct {
        obs_t       val;
        obs_t       mask;
        logic       rdy;
        int         phase;
        logic [7:0] instr;
    } sb_t;

    sb_t        sb[$];
    logic [2:0] m_flags;
    int         total;
    int         bad;

    cpu_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_data (imem_data),
        .pc        (pc),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_s     (alu_s),
        .dmem_rdy  (dmem_rdy),
        .imem_re   (imem_re),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .alu_b_imm (alu_b_imm),
        .imm_ext   (imm_ext),
        .dm_re     (dm_re),
        .dm_we     (dm_we),
        .flags     (flags),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.imem_re   = imem_re;
        o.pc_inc    = pc_inc;
        o.pc_load   = pc_load;
        o.pc_target = pc_target;
        o.rf_ra     = rf_ra;
        o.rf_rb     = rf_rb;
        o.rf_wa     = rf_wa;
        o.rf_we     = rf_we;
        o.wb_sel    = wb_sel;
        o.alu_op    = alu_op;
        o.alu_b_imm = alu_b_imm;
        o.imm_ext   = imm_ext;
        o.dm_re     = dm_re;
        o.dm_we     = dm_we;
        o.flags     = flags;
        o.halted    = halted;
        return o;
    endfunction

    function automatic string phase_name(input int p);
        case (p)
            0: return "FETCH";
            1: return "DECODE";
            2: return "EXEC";
            3: return "MEM";
            4: return "WB";
            default: return "HALT";
        endcase
    endfunction

    function automatic obs_t strobe_mask();
        obs_t m;
        m = '0;
        m.imem_re = 1'b1;
        m.pc_inc  = 1'b1;
        m.pc_load = 1'b1;
        m.rf_we   = 1'b1;
        m.dm_re   = 1'b1;
        m.dm_we   = 1'b1;
        m.flags   = 3'b111;
        m.halted  = 1'b1;
        return m;
    endfunction

    function automatic void push(input obs_t v, input obs_t m, input logic rdy, input int ph, input logic [7:0] ins);
        sb_t e;
        e.val   = v;
        e.mask  = m;
        e.rdy   = rdy;
        e.phase = ph;
        e.instr = ins;
        sb.push_back(e);
    endfunction

    // Reference model: expected per-cycle outputs for one instruction, straight from the ISA timing.
    function automatic void queue_instr(input logic [7:0] ins, input logic [7:0] pc_v,
                                        input logic [2:0] alu_f, input int waits);
        logic [3:0] op;
        logic       is_alu;
        logic       taken;
        obs_t       v;
        obs_t       m;
        op     = ins[7:4];
        is_alu = (op >= 4'h4) && (op <= 4'hC);

        v = '0; v.imem_re = 1'b1; v.flags = m_flags;
        push(v, strobe_mask(), 1'b0, 0, ins);
        v = '0; v.flags = m_flags;
        push(v, strobe_mask(), 1'b0, 1, ins);

        v = '0; v.flags = m_flags; v.rf_ra = ins[3:2]; v.rf_rb = ins[1:0];
        m = strobe_mask(); m.rf_ra = '1; m.rf_rb = '1;
        if (is_alu) begin
            m.alu_op    = '1;
            m.alu_b_imm = 1'b1;
            v.alu_op    = (op == 4'hC) ? 3'd0 : 3'(op - 4'd4);
            v.alu_b_imm = (op == 4'hC);
        end
        if ((op == 4'hD) || (op == 4'hE)) begin
            taken = (op == 4'hD) ? m_flags[2] : m_flags[1];
            if (taken) begin
                v.pc_load   = 1'b1;
                v.pc_target = pc_v + {{4{ins[3]}}, ins[3:0]};
                m.pc_target = '1;
            end else begin
                v.pc_inc = 1'b1;
            end
            push(v, m, 1'b0, 2, ins);
            return;
        end
        push(v, m, 1'b0, 2, ins);
        if (op == 4'hF) begin
            return;
        end
        if (is_alu) begin
            m_flags = alu_f;
        end

        if ((op == 4'h0) || (op == 4'h1)) begin
            v = '0; v.flags = m_flags; v.rf_ra = ins[3:2]; v.rf_rb = ins[1:0];
            v.dm_re = (op == 4'h0);
            v.dm_we = (op == 4'h1);
            m = strobe_mask(); m.rf_ra = '1; m.rf_rb = '1;
`ifdef CU_WAIT_EN
            for (int w = 0; w <= waits; w++) begin
                push(v, m, (w == waits), 3, ins);
            end
`else
            push(v, m, 1'b0, 3, ins);
`endif
        end

        v = '0; v.flags = m_flags; v.pc_inc = 1'b1; v.rf_ra = ins[3:2]; v.rf_rb = ins[1:0];
        m = strobe_mask(); m.rf_ra = '1; m.rf_rb = '1;
        if (op != 4'h1) begin
            v.rf_we   = 1'b1;
            v.rf_wa   = ins[3:2];
            v.imm_ext = {{6{ins[1]}}, ins[1:0]};
            v.wb_sel  = (op == 4'h0) ? 2'b01 : (op == 4'h2) ? 2'b10 : (op == 4'h3) ? 2'b11 : 2'b00;
            m.rf_wa   = '1;
            m.wb_sel  = '1;
            m.imm_ext = '1;
        end
        push(v, m, 1'b0, 4, ins);
    endfunction

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = sample();
        total++;
        if (o !== obs_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_values: got=%h required=%h", o, obs_t'(0));
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_flags = 3'b000;
    endtask

    task automatic test_ldi();
        obs_t o;
        sb_t  e;
        imem_data = 8'h29;
        pc        = 8'h00;
        queue_instr(8'h29, pc, 3'b000, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dmem_rdy = e.rdy;
            @(negedge clk);
            o = sample();
            total++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                bad++;
                $display("[TB] FAIL ldi %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu_flags();
        logic [7:0] ins [4];
        logic [2:0] af  [4];
        obs_t       o;
        sb_t        e;
        ins = '{8'h46, 8'h36, 8'h8B, 8'hC7};
        af  = '{3'b110, 3'b001, 3'b001, 3'b100};
        for (int i = 0; i < 4; i++) begin
            imem_data = ins[i];
            {alu_z, alu_c, alu_s} = af[i];
            queue_instr(ins[i], pc, af[i], 0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                dmem_rdy = e.rdy;
                @(negedge clk);
                o = sample();
                total++;
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL alu_flags %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [7:0] ins [6];
        logic [7:0] pcs [6];
        logic [2:0] af  [6];
        obs_t       o;
        sb_t        e;
        ins = '{8'hDC, 8'h46, 8'hDC, 8'hE7, 8'h56, 8'hE1};
        pcs = '{8'h02, 8'h02, 8'h02, 8'hFC, 8'h10, 8'h10};
        af  = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 6; i++) begin
            imem_data = ins[i];
            pc        = pcs[i];
            {alu_z, alu_c, alu_s} = af[i];
            queue_instr(ins[i], pcs[i], af[i], 0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                dmem_rdy = e.rdy;
                @(negedge clk);
                o = sample();
                total++;
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL branch %s ir=%h pc=%h: got=%h required=%h", phase_name(e.phase), e.instr, pcs[i], o & e.mask, e.val & e.mask);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_mem();
        logic [7:0] ins [2];
        int         wt  [2];
        obs_t       o;
        sb_t        e;
        ins = '{8'h09, 8'h16};
        wt  = '{3, 0};
        for (int i = 0; i < 2; i++) begin
            imem_data = ins[i];
            queue_instr(ins[i], pc, 3'b000, wt[i]);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                dmem_rdy = e.rdy;
                @(negedge clk);
                o = sample();
                total++;
                if ((o & e.mask) !== (e.val & e.mask)) begin
                    bad++;
                    $display("[TB] FAIL mem %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
                end
                @(posedge clk);
                #1;
            end
        end
        dmem_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        obs_t o;
        sb_t  e;
        imem_data = 8'h46;
        {alu_z, alu_c, alu_s} = 3'b111;
        queue_instr(8'h46, pc, 3'b111, 0);
        imem_data = 8'h16;
        queue_instr(8'h16, pc, 3'b000, 5);
        // Run the ADD fully plus the ST up to (and including) its first MEM cycle.
        for (int k = 0; k < 8; k++) begin
            e = sb.pop_front();
            if (k == 4) imem_data = 8'h16;
            if (k < 4)  imem_data = 8'h46;
            dmem_rdy = e.rdy;
            @(negedge clk);
            o = sample();
            total++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                bad++;
                $display("[TB] FAIL mid_mem_pre %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
            end
            if (k < 7) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = sample();
        total++;
        if ((o.dm_we !== 1'b0) || (o.flags !== 3'b000) || (o.imem_re !== 1'b0)) begin
            bad++;
            $display("[TB] FAIL mid_mem_async: dm_we=%b flags=%b imem_re=%b required 0/000/0", o.dm_we, o.flags, o.imem_re);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        m_flags   = 3'b000;
        imem_data = 8'h29;
        queue_instr(8'h29, pc, 3'b000, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dmem_rdy = e.rdy;
            @(negedge clk);
            o = sample();
            total++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                bad++;
                $display("[TB] FAIL mid_mem_post %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        obs_t o;
        obs_t v;
        sb_t  e;
        imem_data = 8'hF0;
        queue_instr(8'hF0, pc, 3'b000, 0);
        v = '0;
        v.halted = 1'b1;
        v.flags  = m_flags;
        for (int k = 0; k < 20; k++) begin
            push(v, strobe_mask(), 1'b0, 5, 8'hF0);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dmem_rdy = e.rdy;
            @(negedge clk);
            o = sample();
            total++;
            if ((o & e.mask) !== (e.val & e.mask)) begin
                bad++;
                $display("[TB] FAIL halt %s ir=%h: got=%h required=%h", phase_name(e.phase), e.instr, o & e.mask, e.val & e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_flags   = 3'b000;
        rst_n     = 1'b0;
        imem_data = 8'h00;
        pc        = 8'h00;
        alu_z     = 1'b0;
        alu_c     = 1'b0;
        alu_s     = 1'b0;
        dmem_rdy  = 1'b0;
        test_reset();
        test_ldi();
        test_alu_flags();
        test_branch();
        test_mem();
        test_reset_mid_mem();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
